// File: rtl/scdiv_pkg.sv
// Shared types and helpers for the stochastic divider job controller.
// lfsr_taps returns a feedback mask for a right-shifting Fibonacci LFSR (bit 0 is the oldest bit).
package scdiv_pkg;

    typedef enum logic [1:0] {IDLE, WARM, RUN, DONE} scdiv_state_e;

    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            4:       lfsr_taps = 16'h0003;
            5:       lfsr_taps = 16'h0005;
            6:       lfsr_taps = 16'h0003;
            7:       lfsr_taps = 16'h0003;
            8:       lfsr_taps = 16'h001D;
            9:       lfsr_taps = 16'h0011;
            10:      lfsr_taps = 16'h0009;
            11:      lfsr_taps = 16'h0005;
            12:      lfsr_taps = 16'h0941;
            13:      lfsr_taps = 16'h1601;
            14:      lfsr_taps = 16'h2A01;
            15:      lfsr_taps = 16'h0003;
            16:      lfsr_taps = 16'h100B;
            default: lfsr_taps = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/scdiv_sng.sv
// Stochastic number generator: one shared LFSR feeding two comparators.
// Both stream bits compare against the same LFSR value so they stay positively correlated.
module scdiv_sng
    import scdiv_pkg::*;
#(
    parameter int BITWIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                en,
    input  logic [BITWIDTH-1:0] seed,
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    output logic                a_bit,
    output logic                b_bit
);

    localparam logic [BITWIDTH-1:0] TAPS = BITWIDTH'(lfsr_taps(BITWIDTH));

    logic [BITWIDTH-1:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            lfsr  <= seed;
            a_bit <= 1'b0;
            b_bit <= 1'b0;
        end else if (en) begin
            lfsr  <= {^(lfsr & TAPS), lfsr[BITWIDTH-1:1]};
            a_bit <= (a > lfsr);
            b_bit <= (b > lfsr);
        end else begin
            a_bit <= 1'b0;
            b_bit <= 1'b0;
        end
    end

endmodule

// File: rtl/scdiv_job_ctrl.sv
// Job controller for the correlation-based stochastic divider: accepts a job,
// streams correlated operands, counts quotient ones and hands back the count.
//   state | meaning
//   IDLE  | ready for a job, divider held clear
//   WARM  | streams running, divider synchronizer filling, quot_bit ignored
//   RUN   | streams running, quot_bit ones counted
//   DONE  | result presented until out_ready
module scdiv_job_ctrl
    import scdiv_pkg::*;
#(
    parameter int                  BITWIDTH = 8,
    parameter int                  LEN_LOG2 = 8,
    parameter int                  WARMUP   = 4,
    parameter logic [BITWIDTH-1:0] SEED     = 'h1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] dividend_bin,
    input  logic [BITWIDTH-1:0] divisor_bin,
    output logic                div_clr,
    output logic                dividend_bit,
    output logic                divisor_bit,
    input  logic                quot_bit,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN_LOG2:0]   quot_bin,
    output logic                err
);

    localparam logic [LEN_LOG2:0]   FULL      = {1'b1, {LEN_LOG2{1'b0}}};
    localparam logic [LEN_LOG2-1:0] WARM_LAST = LEN_LOG2'(WARMUP - 1);
    localparam logic [LEN_LOG2-1:0] RUN_LAST  = {LEN_LOG2{1'b1}};

    scdiv_state_e        state, state_next;
    logic [LEN_LOG2-1:0] cyc;
    logic [LEN_LOG2:0]   ones;
    logic [BITWIDTH-1:0] opa, opb;
    logic                load, stream_en, bad_job;

    assign bad_job = (divisor_bin == '0) || (dividend_bin > divisor_bin);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        div_clr    = 1'b1;
        load       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    load       = 1'b1;
                    state_next = bad_job ? DONE : WARM;
                end
            end
            WARM: begin
                div_clr = 1'b0;
                if (cyc == WARM_LAST) state_next = RUN;
            end
            RUN: begin
                div_clr = 1'b0;
                if (cyc == RUN_LAST) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst) state_next = IDLE;
        // Keyed on the next state so the registered stream bits are zero whenever state is IDLE/DONE.
        stream_en = (state_next == WARM) || (state_next == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cyc      <= '0;
            ones     <= '0;
            opa      <= '0;
            opb      <= '0;
            quot_bin <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (load) begin
                        opa <= dividend_bin;
                        opb <= divisor_bin;
                        cyc <= '0;
                        if (bad_job) begin
                            err      <= 1'b1;
                            quot_bin <= FULL;
                        end
                    end
                end
                WARM: begin
                    if (cyc == WARM_LAST) begin
                        cyc  <= '0;
                        ones <= '0;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                RUN: begin
                    cyc  <= cyc + 1'b1;
                    ones <= ones + {{LEN_LOG2{1'b0}}, quot_bit};
                    if (cyc == RUN_LAST) begin
                        quot_bin <= ones + {{LEN_LOG2{1'b0}}, quot_bit};
                        err      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    scdiv_sng #(.BITWIDTH(BITWIDTH)) u_sng (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .en    (stream_en),
        .seed  (SEED),
        .a     (opa),
        .b     (opb),
        .a_bit (dividend_bit),
        .b_bit (divisor_bit)
    );

endmodule
